// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-type and line-level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and frame controls in, received word and status strobes out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, data_valid, par_err, stp_err, busy
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, data_valid, par_err, stp_err, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and bit-value decision; UART_RX_MAJORITY_EN selects 2-of-3 voting
// around mid-bit instead of a single mid-bit sample.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic rx,
    output logic edge_last,
    output logic bit_value
);
    import uart_pkg::*;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] EDGE_LAST   = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] EDGE_MID    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] EDGE_DECIDE = CW'(OVERSAMPLE / 2 + 1);

    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic          mid_q, mid_d;
    logic          bit_q, bit_d;

    assign edge_last = (edge_cnt_q == EDGE_LAST);
    assign bit_value = bit_q;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] EDGE_EARLY = CW'(OVERSAMPLE / 2 - 1);
    logic early_q, early_d;

    always_comb begin
        early_d = early_q;
        mid_d   = mid_q;
        bit_d   = bit_q;
        if (edge_cnt_q == EDGE_EARLY)  early_d = rx;
        if (edge_cnt_q == EDGE_MID)    mid_d   = rx;
        if (edge_cnt_q == EDGE_DECIDE) bit_d   = majority3(early_q, mid_q, rx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) early_q <= 1'b0;
        else        early_q <= early_d;
    end
`else
    // Decision still lands at OVERSAMPLE/2+1 so frame timing matches the voting build.
    always_comb begin
        mid_d = mid_q;
        bit_d = bit_q;
        if (edge_cnt_q == EDGE_MID)    mid_d = rx;
        if (edge_cnt_q == EDGE_DECIDE) bit_d = mid_q;
    end
`endif

    always_comb begin
        edge_cnt_d = '0;
        if (active) edge_cnt_d = edge_last ? '0 : edge_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            mid_q      <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            mid_q      <= mid_d;
            bit_q      <= bit_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start qualification, LSB-first deserialisation, optional parity, stop check.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.slave bus
);
    import uart_pkg::*;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    uart_state_e           state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  bad_q, bad_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  serr_q, serr_d;
    logic                  edge_last, bit_value, active;

    assign active = (state_q != IDLE) || (bus.RX_IN != LINE_IDLE);

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk       (CLK),
        .rst_n     (RST),
        .active    (active),
        .rx        (bus.RX_IN),
        .edge_last (edge_last),
        .bit_value (bit_value)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        p_data_d  = p_data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        bad_d     = bad_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.RX_IN != LINE_IDLE) begin
                    state_d   = START;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    bad_d     = 1'b0;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (edge_last) state_d = (bit_value == LINE_IDLE) ? IDLE : DATA;
            end
            DATA: begin
                if (edge_last) begin
                    shift_d[bit_cnt_q] = bit_value;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (edge_last) begin
                    if (bit_value != ((^shift_q) ^ (par_typ_q == PAR_ODD))) begin
                        perr_d = 1'b1;
                        bad_d  = 1'b1;
                    end
                    state_d = STOP;
                end
            end
            STOP: begin
                if (edge_last) begin
                    if (!bit_value) begin
                        serr_d = 1'b1;
                    end else if (!bad_q) begin
                        p_data_d = shift_q;
                        valid_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            p_data_q  <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            bad_q     <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            p_data_q  <= p_data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            bad_q     <= bad_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.data_valid = valid_q;
    assign bus.par_err    = perr_q;
    assign bus.stp_err    = serr_q;
    assign bus.busy       = (state_q != IDLE);

endmodule
